// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared mode/state encodings and index helper for the arbiter
package arb_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // (a + b) mod n for operands already in 0..n-1
    function automatic int wrap_add(input int a, input int b, input int n);
        int s;
        s = a + b;
        return (s >= n) ? s - n : s;
    endfunction

endpackage

// File: rtl/prio_enc_n.sv
// rtl/prio_enc_n.sv - N-input search: highest-index-first, or ascending from a start pointer
module prio_enc_n
    import arb_pkg::*;
#(
    parameter  int N    = 8,
    localparam int IDXW = $clog2(N)
) (
    input  logic [N-1:0]    vec,
    input  logic [IDXW-1:0] start,
    input  logic            desc,
    output logic            found,
    output logic [IDXW-1:0] idx
);

    logic [N-1:0] rot;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        rot   = '0;
        for (int i = 0; i < N; i++) begin
            rot[i] = vec[wrap_add(i, int'(start), N)];
        end
        if (desc) begin
            for (int i = 0; i < N; i++) begin
                if (vec[i]) begin
                    found = 1'b1;
                    idx   = IDXW'(i);
                end
            end
        end else begin
            // Walk downwards so the lowest rotated position is the last write; un-rotate on the way out
            for (int i = N - 1; i >= 0; i--) begin
                if (rot[i]) begin
                    found = 1'b1;
                    idx   = IDXW'(wrap_add(i, int'(start), N));
                end
            end
        end
    end

endmodule

// File: rtl/rr_prio_arbiter.sv
// rtl/rr_prio_arbiter.sv - registered fixed/round-robin arbiter with optional grant lock
module rr_prio_arbiter
    import arb_pkg::*;
#(
    parameter  int N       = 8,
    parameter  int LOCK_EN = 1,
    localparam int IDXW    = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            mode,
    input  logic [N-1:0]    req,
    output logic [N-1:0]    gnt,
    output logic [IDXW-1:0] gnt_idx,
    output logic            gnt_valid
);

    state_t          state_q, state_d;
    logic [IDXW-1:0] rr_ptr_q, rr_ptr_d;
    logic [N-1:0]    gnt_q, gnt_d;
    logic [IDXW-1:0] gnt_idx_q, gnt_idx_d;

    logic            enc_found;
    logic [IDXW-1:0] enc_idx;
    logic            hold;

    prio_enc_n #(.N(N)) u_enc (
        .vec   (req),
        .start (rr_ptr_q),
        .desc  (mode == MODE_FIXED),
        .found (enc_found),
        .idx   (enc_idx)
    );

    assign hold = (LOCK_EN != 0) && (state_q == BUSY) && req[gnt_idx_q];

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        gnt_d     = gnt_q;
        gnt_idx_d = gnt_idx_q;
        if (en && !hold) begin
            // Release and re-arbitrate share this edge, so a dropped lock never costs a cycle
            if (enc_found) begin
                gnt_d          = '0;
                gnt_d[enc_idx] = 1'b1;
                gnt_idx_d      = enc_idx;
                state_d        = (LOCK_EN != 0) ? BUSY : IDLE;
                if (mode == MODE_RR) begin
                    rr_ptr_d = (enc_idx == IDXW'(N - 1)) ? '0 : enc_idx + 1'b1;
                end
            end else begin
                gnt_d     = '0;
                gnt_idx_d = '0;
                state_d   = IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rr_ptr_q  <= '0;
            gnt_q     <= '0;
            gnt_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            gnt_q     <= gnt_d;
            gnt_idx_q <= gnt_idx_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = gnt_idx_q;
    assign gnt_valid = |gnt_q;

endmodule

// File: tb/tb_rr_prio_arbiter.sv
// tb/tb_rr_prio_arbiter.sv - bench driving an unlocked and a locked arbiter against a behavioural model
module tb_rr_prio_arbiter;

    localparam int N    = 8;
    localparam int IDXW = $clog2(N);

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            en = 1'b1;
    logic            mode = 1'b0;
    logic [N-1:0]    req = '0;

    logic [N-1:0]    gnt0, gnt1;
    logic [IDXW-1:0] idx0, idx1;
    logic            vld0, vld1;

    int  n_cmp = 0;
    int  n_fail = 0;
    bit  check_on = 1'b0;

    int  m_idx[2];
    bit  m_vld[2];
    int  m_ptr[2];

    always #5 clk = ~clk;

    rr_prio_arbiter #(.N(N), .LOCK_EN(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .req(req),
        .gnt(gnt0), .gnt_idx(idx0), .gnt_valid(vld0)
    );

    rr_prio_arbiter #(.N(N), .LOCK_EN(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .req(req),
        .gnt(gnt1), .gnt_idx(idx1), .gnt_valid(vld1)
    );

    function automatic int pick(input logic m, input logic [N-1:0] r, input int ptr);
        if (m == 1'b0) begin
            for (int i = N - 1; i >= 0; i--) if (r[i]) return i;
        end else begin
            for (int k = 0; k < N; k++) if (r[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                m_idx[d] = 0; m_vld[d] = 0; m_ptr[d] = 0;
            end else if (en) begin
                if (!(d == 1 && m_vld[d] && req[m_idx[d]])) begin
                    int w;
                    w = pick(mode, req, m_ptr[d]);
                    if (w >= 0) begin
                        m_vld[d] = 1; m_idx[d] = w;
                        if (mode) m_ptr[d] = (w + 1) % N;
                    end else begin
                        m_vld[d] = 0; m_idx[d] = 0;
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (check_on) begin
            int eg0, eg1;
            eg0 = m_vld[0] ? (1 << m_idx[0]) : 0;
            eg1 = m_vld[1] ? (1 << m_idx[1]) : 0;
            chk("dut0.gnt",       int'(gnt0), eg0);
            chk("dut0.gnt_idx",   int'(idx0), m_idx[0]);
            chk("dut0.gnt_valid", int'(vld0), int'(m_vld[0]));
            chk("dut1.gnt",       int'(gnt1), eg1);
            chk("dut1.gnt_idx",   int'(idx1), m_idx[1]);
            chk("dut1.gnt_valid", int'(vld1), int'(m_vld[1]));
            chk("dut0.onehot",    int'($countones(gnt0) <= 1), 1);
            chk("dut1.onehot",    int'($countones(gnt1) <= 1), 1);
        end
    end

    task automatic step(input logic e, input logic m, input logic [N-1:0] r);
        @(negedge clk);
        en = e; mode = m; req = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        step(1, 0, 8'h00);
        check_on = 1'b1;
        step(1, 0, 8'h00);
        chk("reset.gnt0", int'(gnt0), 0);
        chk("reset.vld1", int'(vld1), 0);
        rst_n = 1'b1;

        step(1, 0, 8'h00);
        chk("empty.gnt0", int'(gnt0), 0);
        chk("empty.idx0", int'(idx0), 0);
        step(1, 0, 8'h01);
        chk("fix01.idx0", int'(idx0), 0);
        step(1, 0, 8'h50);
        chk("fix50.idx0", int'(idx0), 6);
        chk("fix50.gnt0", int'(gnt0), 8'h40);
        step(1, 0, 8'hFF);
        chk("fixFF.idx0", int'(idx0), 7);
        chk("fixFF.lock1", int'(idx1), 6);

        rst_n = 1'b0;
        step(1, 0, 8'hFF);
        chk("midrst.vld0", int'(vld0), 0);
        chk("midrst.gnt1", int'(gnt1), 0);
        rst_n = 1'b1;

        for (int k = 0; k < 9; k++) begin
            step(1, 1, 8'hFF);
            chk("rr.idx0", int'(idx0), k % 8);
        end
        chk("rr.lock1", int'(idx1), 0);

        step(1, 1, 8'h00);
        chk("rr_empty.vld1", int'(vld1), 0);
        step(1, 1, 8'h0C);
        chk("lock.grant", int'(idx1), 2);
        step(1, 1, 8'h0C);
        step(1, 1, 8'h0C);
        chk("lock.held", int'(idx1), 2);
        step(1, 1, 8'h08);
        chk("lock.release", int'(idx1), 3);
        chk("lock.valid", int'(vld1), 1);

        step(0, 1, 8'h81);
        step(0, 0, 8'hF0);
        chk("freeze.idx0", int'(idx0), 3);
        chk("freeze.idx1", int'(idx1), 3);

        step(1, 0, 8'h88);
        chk("modesw.lock1", int'(idx1), 3);
        chk("modesw.fix0", int'(idx0), 7);
        step(1, 0, 8'h81);
        chk("modesw.rel1", int'(idx1), 7);
        step(1, 1, 8'hFF);
        chk("ptrheld.idx0", int'(idx0), 4);
        step(1, 1, 8'h00);
        chk("final.gnt0", int'(gnt0), 0);
        chk("final.gnt1", int'(gnt1), 0);

        @(negedge clk);
        check_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_prio_arbiter.md
Name: rr_prio_arbiter

Overview:
- Parametrised N-input arbiter. It is the sequential successor to the 8-to-3 priority encoder.
- Two modes, selectable at run time:
  - fixed priority, where the highest index wins (same priority order as the encoder);
  - round-robin, with a rotating pointer.
- Output is a registered one-hot grant plus a binary index, with an optional grant lock.
- Sits in front of shared resources (bus, memory port) and replaces ad-hoc encoder+register pairs.

Parameters:
- N, 8, number of requesters (2..32).
- LOCK_EN, 1, 1 = hold grant while the granted requester keeps req high; 0 = re-arbitrate every enabled cycle.
- IDXW (localparam), $clog2(N), width of the grant index.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- en  input  1  arbitration enable; 0 freezes all state and outputs.
- mode  input  1  0 = fixed priority (highest index wins), 1 = round-robin.
- req  input  N  request vector, bit i = requester i.
- gnt  output  N  registered one-hot grant; all-zero when no grant.
- gnt_idx  output  IDXW  binary index of the granted requester; 0 when no grant.
- gnt_valid  output  1  1 when gnt is non-zero.

Behaviour:
- Clock and reset: one clock, clk. Reset is rst_n, synchronous and active-low.
- Reset (rst_n=0 at a rising edge):
  - gnt=0, gnt_idx=0, gnt_valid=0;
  - rr_ptr=0;
  - state=IDLE.
  - Reset mid-grant drops the grant at that edge, with no completion.
- States:
  - IDLE: no grant held.
  - BUSY: grant held, only used when LOCK_EN=1.
- Latency: req is sampled at edge k; the resulting gnt/gnt_idx/gnt_valid are visible after edge k. No combinational path from req to the outputs.
- When an arbitration happens (each enabled edge):
  - LOCK_EN=0: every enabled edge arbitrates.
  - LOCK_EN=1, IDLE: arbitrate. If any req is high → BUSY, else stay IDLE.
  - LOCK_EN=1, BUSY, req[gnt_idx]=1: hold all outputs, stay BUSY.
  - LOCK_EN=1, BUSY, req[gnt_idx]=0: release and re-arbitrate at the same edge. No dead cycle.
    - Any req high → new grant, stay BUSY.
    - No req → gnt_valid=0, IDLE.
- Fixed mode (mode=0): winner = highest i with req[i]=1.
- Round-robin mode (mode=1):
  - Winner = first i with req[i]=1, searching ascending from rr_ptr and wrapping N-1→0.
  - On each new grant to index w, rr_ptr ← (w+1) mod N. For w=N-1, rr_ptr wraps to 0.
- rr_ptr handling:
  - rr_ptr updates only on a new grant in mode=1.
  - In mode=0 rr_ptr holds.
  - A held (locked) grant does not update rr_ptr.
- Mode change: sampled only at arbitration edges. A mode change while BUSY does not break the lock.
- Empty request: req=0 at an arbitration edge → gnt=0, gnt_idx=0, gnt_valid=0.
- en=0: state, rr_ptr and outputs hold. Reset has priority over en.
- Output invariants:
  - gnt is always one-hot or zero.
  - gnt_valid == |gnt.
  - gnt == (1<<gnt_idx) whenever gnt_valid=1.

Decomposition:
- Package arb_pkg contains:
  - MODE_FIXED=1'b0 and MODE_RR=1'b1;
  - the state encoding IDLE/BUSY.
- Sub-module prio_enc_n (combinational, parameter N):
  - inputs: a vector and a start pointer;
  - outputs: found flag and index.
  - Fixed mode uses it as a highest-index-first search. Round-robin uses it as an ascending search from the pointer, implemented as a rotate, search and un-rotate.
- The arbiter top holds the FSM, rr_ptr and the output registers.

Test Plan:
- Reset and empty: rst_n=0 for 2 cycles, then req=8'h00 → gnt=0, gnt_idx=0, gnt_valid=0. Assert rst_n=0 mid-grant → outputs 0 at that edge.
- Fixed priority, LOCK_EN=0, mode=0:
  - req=8'h01 → gnt_idx=0;
  - req=8'h50 → gnt_idx=6, gnt=8'h40;
  - req=8'hFF → gnt_idx=7.
  - Each result appears one cycle after req.
- Round-robin rotation, LOCK_EN=0, mode=1, req=8'hFF held for 9 cycles → gnt_idx sequence 0,1,2,...,7,0 (pointer wrap).
- Lock and release, LOCK_EN=1, mode=1:
  - req=8'h0C → grant idx 2, held while req[2]=1;
  - drop bit 2 (req=8'h08) → idx 3 on that same edge, no gap.
- Freeze and mode switch:
  - en=0 with req changing → outputs and rr_ptr unchanged.
  - mode 1→0 while BUSY → lock kept; after release, highest-index winner is selected.
